// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width and the
// divider sequencing states.
package mdu_pkg;

  localparam int MDU_WIDTH    = 32;
  localparam int DIV_LAST_CNT = MDU_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/CLA32bits.sv
// 32-bit carry-lookahead adder: 4-bit groups with lookahead carries between
// groups, ripple inside each group.
module CLA32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    grp_c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      c[4*k] = grp_c[k];
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[8];

endmodule

// File: rtl/div_int_unit.sv
// One restoring division step: shift {R,Q} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it did not borrow.
module div_int_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             no_borrow;
  logic             unused_r_msb;

  // R stays below D, so its top bit is always clear going into a step.
  assign unused_r_msb = r[WIDTH];

  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign q_sh = {q[WIDTH-2:0], 1'b0};

  if (WIDTH == MDU_WIDTH) begin : g_cla
    CLA32bits u_cla (
      .a    (r_sh[WIDTH-1:0]),
      .b    (~d),
      .cin  (1'b1),
      .sum  (diff),
      .cout (carry)
    );
  end else begin : g_add
    assign {carry, diff} = {1'b0, r_sh[WIDTH-1:0]} + {1'b0, ~d} + (WIDTH+1)'(1);
  end

  // Shifted R with its extra bit set always exceeds D, whatever the carry.
  assign no_borrow = r_sh[WIDTH] | carry;

  assign r_next = no_borrow ? {1'b0, diff} : r_sh;
  assign q_next = {q_sh[WIDTH-1:1], no_borrow};

endmodule

// File: rtl/div_int_seq.sv
// Sequential restoring integer divider, one quotient bit per clock, signed and
// unsigned, using the MDU start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; divide-by-zero is answered straight from here
// RUN   | one shift-subtract step per clock, WIDTH steps
// FIX   | apply result signs, load outputs
// DONE  | done pulse for one cycle
module div_int_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] d_mag;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign dvd_neg = sign & dividend[WIDTH-1];
  assign dvs_neg = sign & divisor[WIDTH-1];
  // -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  div_int_unit #(.WIDTH(WIDTH)) u_step (
    .r      (r_acc),
    .q      (q_acc),
    .d      (d_mag),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r_acc     <= '0;
      q_acc     <= '0;
      d_mag     <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              r_acc <= '0;
              q_acc <= dvd_mag;
              d_mag <= dvs_mag;
              q_neg <= dvd_neg ^ dvs_neg;
              r_neg <= dvd_neg;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc <= r_step;
          q_acc <= q_step;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Remainder takes the dividend's sign, quotient truncates toward zero.
          quotient  <= q_neg ? -q_acc : q_acc;
          remainder <= r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          div_zero  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_int_seq.md
Name: div_int_seq

Overview:
Sequential 32-bit integer divider, the inverse of the shift-add multiplier datapath. It uses restoring shift-subtract with one quotient bit per clock, and supports signed and unsigned modes. It sits beside the multiplier in the ALU/MDU and is driven by the same start/done handshake.

Parameters:
WIDTH, 32, operand width in bits; all ports scale with it.
CNT_W, 6, iteration counter width; must be at least clog2(WIDTH)+1.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only while idle
sign  input  1  1 = signed (two's complement) operands, 0 = unsigned
dividend  input  WIDTH  dividend, sampled with start
divisor  input  WIDTH  divisor, sampled with start
busy  output  WIDTH=1  high from the start-accept edge until done is asserted
done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
div_zero  output  1  divisor was 0 for the last accepted operation; held with results
quotient  output  WIDTH  result; held until the next accepted start
remainder  output  WIDTH  result; held until the next accepted start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While rst=1, all outputs are 0 and the state is IDLE.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 with divisor!=0 (edge E0): latch operand magnitudes (sign=1 → absolute values), latch sign flags q_neg = sign & (dividend[MSB]^divisor[MSB]) and r_neg = sign & dividend[MSB].
  - Clear partial remainder R (WIDTH+1 bits), load Q = |dividend|, set cnt=0, busy=1, go to RUN.
- IDLE, start=1 with divisor==0: go directly to DONE at E0 with quotient = all ones, remainder = dividend (raw input), div_zero=1. Result is visible, with done=1, in the cycle after E0.
- RUN, each edge (one div_int_unit step):
  - {R,Q} shifts left by 1; T = R − D.
  - If T ≥ 0: R = T and Q[0] = 1, else restore and Q[0] = 0.
  - cnt increments. After the step with cnt==WIDTH−1 (edge E0+32), go to FIX.
- FIX (edge E0+33):
  - quotient = q_neg ? −Q : Q; remainder = r_neg ? −R : R. Remainder sign follows the dividend.
  - div_zero=0, busy=0, go to DONE, done=1.
- Latency is 33 edges after the start-accept edge (34 cycles including the accept cycle).
- DONE:
  - done=1 for exactly this cycle, then go to IDLE.
  - A start seen in DONE is ignored; start is only accepted in IDLE.
- start while busy: ignored. Operand inputs are don't-care outside the accept edge.
- Signed overflow: (−2^31)/(−1) gives quotient 0x80000000, remainder 0, with no flag (wrap-around, like the multiplier's truncation).
- Outputs quotient, remainder and div_zero change only at FIX, at the divide-by-zero accept, or on reset.
- Reset mid-operation: abort immediately, go to IDLE, clear all outputs. No done is produced for the aborted operation.

Decomposition:
- Shared package (mdu_pkg):
  - Constant MDU_WIDTH=32.
  - State encoding typedef div_state_t {IDLE, RUN, FIX, DONE}.
  - Constant DIV_LAST_CNT = MDU_WIDTH−1.
- Sub-module div_int_unit: combinational single restoring step, the counterpart of the multiplier step unit.
  - Inputs: R[WIDTH:0], Q[WIDTH−1:0], D[WIDTH−1:0].
  - Outputs: R_next, Q_next.
  - Reuses CLA32bits for the subtraction (invert D, carry-in 1).
- The top level holds the FSM, counter, sign fix-up and output registers.

Test Plan:
1. Unsigned: sign=0, dividend=100, divisor=7, start pulse → busy=1 next cycle; done after 33 edges; quotient=14, remainder=2, div_zero=0.
2. Signed mixed: sign=1, dividend=−100 (0xFFFFFF9C), divisor=7 → quotient=0xFFFFFFF2 (−14), remainder=0xFFFFFFFE (−2). Also check −100/−7 → quotient=14, remainder=0xFFFFFFFE.
3. Divide by zero: dividend=0x12345678, divisor=0 → done in the next cycle, quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1, busy never observed high past the accept.
4. Edge values:
   - unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
   - signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
   - 5/9 → quotient=0, remainder=5.
5. Handshake: start held high continuously across two operations → exactly one accept per IDLE visit. A start pulse mid-RUN changes nothing, and results hold stable until the next accept.
6. Reset at cycle 10 of RUN → all outputs 0 immediately (asynchronous), no done. A fresh 50/5 afterwards gives quotient=10, remainder=0.
